// File: rtl/barrel_pipe_if.sv
// rtl/barrel_pipe_if.sv - operand and result valid/ready streams for barrel_pipe
interface barrel_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/barrel_pipe.sv
// rtl/barrel_pipe.sv - pipelined barrel shifter/rotator with global-stall valid/ready flow
module barrel_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic          clk,
  input  logic          rst,
  barrel_pipe_if.slave  bus
);
  localparam int LVL = $clog2(WIDTH);
  localparam int NC  = (PIPE > 1) ? PIPE - 1 : 1;

  // First level index of register group g; earlier groups absorb the remainder.
  function automatic int grp_lo(input int g);
    return g * (LVL / PIPE) + ((g < LVL % PIPE) ? g : LVL % PIPE);
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] d, input int s,
                                                 input logic [2:0] mode);
    case (mode)
      3'b000:  return d << s;
      3'b001:  return d >> s;
      3'b010:  return WIDTH'($signed(d) >>> s);
      3'b011:  return (d << s) | (d >> (WIDTH - s));
      3'b100:  return (d >> s) | (d << (WIDTH - s));
      default: return d;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] apply_levels(input logic [WIDTH-1:0] d,
                                                    input logic [LVL-1:0] amt,
                                                    input logic [2:0] mode,
                                                    input int lo, input int hi);
    logic [WIDTH-1:0] v;
    v = d;
    for (int j = 0; j < LVL; j++) begin
      if (j >= lo && j < hi && amt[j]) v = shift_one(v, 1 << j, mode);
    end
    return v;
  endfunction

  logic [WIDTH-1:0] r_data  [PIPE];
  logic             r_valid [PIPE];
  logic [LVL-1:0]   r_amt   [NC];
  logic [2:0]       r_mode  [NC];
  logic             r_zero;
  logic [WIDTH-1:0] w_next  [PIPE];
  logic             w_advance;
  logic             w_in_ready;

  assign w_advance  = !r_valid[PIPE-1] || bus.out_ready;
  assign w_in_ready = w_advance && !rst;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid[PIPE-1];
  assign bus.out_data  = r_data[PIPE-1];
  assign bus.out_zero  = r_zero;

  for (genvar g = 0; g < PIPE; g++) begin : g_level
    if (g == 0) begin : g_head
      assign w_next[g] = apply_levels(bus.in_data, bus.in_amt, bus.in_mode,
                                      grp_lo(g), grp_lo(g + 1));
    end else begin : g_body
      assign w_next[g] = apply_levels(r_data[g-1], r_amt[g-1], r_mode[g-1],
                                      grp_lo(g), grp_lo(g + 1));
    end
  end

  // Whole pipeline moves or holds as one; bubbles are never squeezed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        r_data[k]  <= '0;
        r_valid[k] <= 1'b0;
      end
      for (int k = 0; k < NC; k++) begin
        r_amt[k]  <= '0;
        r_mode[k] <= '0;
      end
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_valid[0] <= bus.in_valid && w_in_ready;
      for (int k = 1; k < PIPE; k++) r_valid[k] <= r_valid[k-1];
      for (int k = 0; k < PIPE; k++) r_data[k] <= w_next[k];
      if (PIPE > 1) begin
        r_amt[0]  <= bus.in_amt;
        r_mode[0] <= bus.in_mode;
      end
      for (int k = 1; k < NC; k++) begin
        r_amt[k]  <= r_amt[k-1];
        r_mode[k] <= r_mode[k-1];
      end
      r_zero <= (w_next[PIPE-1] == '0);
    end
  end
endmodule

// File: tb/tb_barrel_pipe.sv
// tb/tb_barrel_pipe.sv - scoreboard bench for barrel_pipe: directed vectors plus parameter sweep
module tb_barrel_pipe;
  localparam int W  = 32;
  localparam int P  = 2;
  localparam int NB = 2000;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic srst = 1'b1;
  bit   sweep_go    = 1'b0;
  int   sw_finished = 0;
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_errors    = 0;
  bit   chk_lat     = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;
  exp_t dq[$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_pipe_if #(.WIDTH(W)) bus ();
  barrel_pipe #(.WIDTH(W), .PIPE(P)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m,
                      input logic [31:0] e);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    #1;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("send_accepted", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) dq.push_back('{data: e, acc: cyc});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && dq.size() > 0; i++) @(negedge clk);
    check("drain", 64'(dq.size()), 64'd0);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("dir_q_nonempty", 64'(dq.size() != 0), 64'd1);
      if (dq.size() != 0) begin
        me = dq.pop_front();
        check("dir_data", 64'(bus.out_data), 64'(me.data));
        check("dir_zero", 64'(bus.out_zero), 64'(me.data == 32'd0));
        if (chk_lat) check("dir_latency", 64'(cyc - me.acc), 64'(P));
      end
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_sweep
    localparam int SW = (k < 2) ? 8 : ((k < 4) ? 32 : 64);
    localparam int SA = $clog2(SW);
    localparam int SP = (k % 2 == 0) ? 1 : SA;

    barrel_pipe_if #(.WIDTH(SW)) sbus ();
    barrel_pipe #(.WIDTH(SW), .PIPE(SP)) u_dut (.clk(clk), .rst(srst), .bus(sbus));

    logic [SW-1:0] sq[$];

    function automatic logic [SW-1:0] ref_model(input logic [SW-1:0] d, input int a,
                                                input logic [2:0] m);
      logic [2*SW-1:0] dd;
      dd = {d, d};
      case (m)
        3'd0: return d << a;
        3'd1: return d >> a;
        3'd2: return SW'($signed(d) >>> a);
        3'd3: begin dd = dd << a; return dd[2*SW-1:SW]; end
        3'd4: begin dd = dd >> a; return dd[SW-1:0]; end
        default: return d;
      endcase
    endfunction

    initial begin
      int sent, got, n;
      logic [63:0] tmp;
      logic [SW-1:0] e;
      sent = 0;
      got  = 0;
      n    = 0;
      sbus.in_valid  = 1'b0;
      sbus.in_data   = '0;
      sbus.in_amt    = '0;
      sbus.in_mode   = '0;
      sbus.out_ready = 1'b0;
      wait (sweep_go);
      while ((sent < NB || sq.size() > 0) && n < 20000) begin
        @(negedge clk);
        tmp = {$urandom(), $urandom()};
        sbus.in_valid  = (sent < NB) && ($urandom_range(0, 3) != 0);
        sbus.in_data   = tmp[SW-1:0];
        sbus.in_amt    = SA'($urandom_range(0, SW - 1));
        sbus.in_mode   = 3'($urandom_range(0, 7));
        sbus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (sbus.out_valid && sbus.out_ready) begin
          got++;
          check($sformatf("sw%0d_q_nonempty", k), 64'(sq.size() != 0), 64'd1);
          if (sq.size() != 0) begin
            e = sq.pop_front();
            check($sformatf("sw%0d_data", k), 64'(sbus.out_data), 64'(e));
            check($sformatf("sw%0d_zero", k), 64'(sbus.out_zero), 64'(e == '0));
          end
        end
        if (sbus.in_valid && sbus.in_ready) begin
          sq.push_back(ref_model(sbus.in_data, int'(sbus.in_amt), sbus.in_mode));
          sent++;
        end
        n++;
      end
      sbus.in_valid = 1'b0;
      check($sformatf("sw%0d_beats_in", k), 64'(sent), 64'(NB));
      check($sformatf("sw%0d_beats_out", k), 64'(got), 64'(sent));
      sw_finished++;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_zero", 64'(bus.out_zero), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    send(32'h80000001, 5'd1,  3'b000, 32'h00000002);
    send(32'h80000000, 5'd4,  3'b001, 32'h08000000);
    send(32'h80000000, 5'd4,  3'b010, 32'hF8000000);
    send(32'h40000000, 5'd31, 3'b010, 32'h00000000);
    send(32'h80000000, 5'd4,  3'b011, 32'h00000008);
    send(32'h00000001, 5'd1,  3'b100, 32'h80000000);
    send(32'h12345678, 5'd0,  3'b100, 32'h12345678);
    send(32'hDEADBEEF, 5'd7,  3'b111, 32'hDEADBEEF);
    send(32'hC0FFEE01, 5'd13, 3'b101, 32'hC0FFEE01);
    wait_drain();

    // Backpressure: six beats against a consumer stalled for five cycles.
    chk_lat = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'd1, 5'(i), 3'b000, 32'd1 << i);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (4) begin
          #1;
          if (bus.out_valid) begin
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold", 64'(bus.out_data), 64'd1);
          end
          @(negedge clk);
        end
        #1;
        check("bp_full_valid", 64'(bus.out_valid), 64'd1);
        check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two beats in flight; a beat presented during reset must be dropped.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'hA5A5A5A5, 5'd3, 3'b011, 32'h2D2D2D2D);
    send(32'h0000F000, 5'd8, 3'b001, 32'h000000F0);
    #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    dq.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000005;
    bus.in_amt    = 5'd0;
    bus.in_mode   = 3'b000;
    #1;
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_data", 64'(bus.out_data), 64'd0);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    chk_lat = 1'b1;
    send(32'h80000010, 5'd4, 3'b010, 32'hF8000001);
    wait_drain();

    @(negedge clk);
    srst = 1'b0;
    sweep_go = 1'b1;
    for (int i = 0; i < 30000 && sw_finished < 6; i++) @(negedge clk);
    check("sweep_done", 64'(sw_finished), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
